// File: rtl/execute_mc.sv
// ============================================================================
// Module   : execute_mc
// Brief    : LEGv8 execute stage with operand forwarding, an EX/MEM output
//            register and an iterative shift-add MUL.
// Revision : 1.0
// ============================================================================
`default_nettype none

module execute_mc #(
  parameter int N        = 64,
  parameter int BR_SHIFT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic         AluSrc,
  input  logic [3:0]   AluControl,
  input  logic [N-1:0] PC_E,
  input  logic [N-1:0] signImm_E,
  input  logic [N-1:0] readData1_E,
  input  logic [N-1:0] readData2_E,
  input  logic [1:0]   fwdA,
  input  logic [1:0]   fwdB,
  input  logic [N-1:0] fwdMem_E,
  input  logic [N-1:0] fwdWb_E,
  input  logic         stall_M,
  input  logic         flush,
  output logic         busy,
  output logic         valid_M,
  output logic [N-1:0] PCBranch_M,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] writeData_M,
  output logic         zero_M
);

  localparam int             CW       = $clog2(N + 1);
  localparam logic [CW-1:0]  CNT_DONE = CW'(N);
  localparam logic [3:0]     OP_MUL   = 4'b1000;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [N-1:0]   prod_q, prod_d;
  logic [N-1:0]   pcb_hold_q, pcb_hold_d;
  logic [N-1:0]   wd_hold_q, wd_hold_d;
  logic           valid_q, valid_d;
  logic [N-1:0]   pcb_q, pcb_d;
  logic [N-1:0]   alu_q, alu_d;
  logic [N-1:0]   wd_q, wd_d;
  logic           zero_q, zero_d;

  logic [N-1:0]   w_opa;
  logic [N-1:0]   w_fwd_b;
  logic [N-1:0]   w_opb;
  logic [N-1:0]   w_alu;
  logic [N-1:0]   w_pcb;
  logic           w_accept;

  always_comb begin
    case (fwdA)
      2'b01:   w_opa = fwdWb_E;
      2'b10:   w_opa = fwdMem_E;
      default: w_opa = readData1_E;
    endcase
    case (fwdB)
      2'b01:   w_fwd_b = fwdWb_E;
      2'b10:   w_fwd_b = fwdMem_E;
      default: w_fwd_b = readData2_E;
    endcase
  end

  assign w_opb = AluSrc ? signImm_E : w_fwd_b;
  assign w_pcb = PC_E + (signImm_E << BR_SHIFT);

  // MUL never uses this result; it is produced by the iterative datapath.
  always_comb begin
    case (AluControl)
      4'b0000: w_alu = w_opa & w_opb;
      4'b0001: w_alu = w_opa | w_opb;
      4'b0010: w_alu = w_opa + w_opb;
      4'b0110: w_alu = w_opa - w_opb;
      4'b0111: w_alu = w_opb;
      4'b1100: w_alu = ~(w_opa | w_opb);
      default: w_alu = '0;
    endcase
  end

  assign busy     = (state_q == S_MUL);
  assign w_accept = valid_E & ~busy & ~stall_M & ~flush;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    prod_d     = prod_q;
    pcb_hold_d = pcb_hold_q;
    wd_hold_d  = wd_hold_q;
    valid_d    = valid_q;
    pcb_d      = pcb_q;
    alu_d      = alu_q;
    wd_d       = wd_q;
    zero_d     = zero_q;

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            if (AluControl == OP_MUL) begin
              mcand_d    = w_opa;
              mplier_d   = w_opb;
              pcb_hold_d = w_pcb;
              wd_hold_d  = w_fwd_b;
              prod_d     = '0;
              cnt_d      = '0;
              valid_d    = 1'b0;
              state_d    = S_MUL;
            end else begin
              alu_d   = w_alu;
              pcb_d   = w_pcb;
              wd_d    = w_fwd_b;
              zero_d  = (w_alu == '0);
              valid_d = 1'b1;
            end
          end else if (!stall_M) begin
            valid_d = 1'b0;
          end
        end
        S_MUL: begin
          if (cnt_q != CNT_DONE) begin
            // Iterations keep running under stall; only the output register waits.
            if (mplier_q[0]) prod_d = prod_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (!stall_M) valid_d = 1'b0;
          end else if (!stall_M) begin
            alu_d   = prod_q;
            pcb_d   = pcb_hold_q;
            wd_d    = wd_hold_q;
            zero_d  = (prod_q == '0);
            valid_d = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      prod_q     <= '0;
      pcb_hold_q <= '0;
      wd_hold_q  <= '0;
      valid_q    <= 1'b0;
      pcb_q      <= '0;
      alu_q      <= '0;
      wd_q       <= '0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      prod_q     <= prod_d;
      pcb_hold_q <= pcb_hold_d;
      wd_hold_q  <= wd_hold_d;
      valid_q    <= valid_d;
      pcb_q      <= pcb_d;
      alu_q      <= alu_d;
      wd_q       <= wd_d;
      zero_q     <= zero_d;
    end
  end

  assign valid_M     = valid_q;
  assign PCBranch_M  = pcb_q;
  assign aluResult_M = alu_q;
  assign writeData_M = wd_q;
  assign zero_M      = zero_q;

endmodule

`default_nettype wire
